// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo result path: solution field layout and
// the encoding used to tag which execution unit produced a CDB broadcast.
package tomasulo_pkg;

  localparam int SOL_W   = 23;
  localparam int DEST_HI = 22;
  localparam int DEST_LO = 19;
  localparam int TAG_HI  = 18;
  localparam int TAG_LO  = 16;
  localparam int VAL_HI  = 15;
  localparam int VAL_LO  = 0;

  typedef logic [SOL_W-1:0] solution_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result/CDB bundle between the execution units, the arbiter and the CDB consumers.
interface cdb_arbiter_if;
  import tomasulo_pkg::*;

  logic      alu_done;
  solution_t alu_solution;
  logic      mem_done;
  solution_t mem_solution;
  logic      alu_full;
  logic      mem_full;
  logic      cdb_done;
  solution_t cdb_solution;
  src_e      cdb_source;
  logic      overflow;

  modport master (
    output alu_done, alu_solution, mem_done, mem_solution,
    input  alu_full, mem_full, cdb_done, cdb_solution, cdb_source, overflow
  );

  modport slave (
    input  alu_done, alu_solution, mem_done, mem_solution,
    output alu_full, mem_full, cdb_done, cdb_solution, cdb_source, overflow
  );

endinterface

// File: rtl/result_fifo.sv
// Per-source result buffer. Fullness comes from the registered count, so a pop
// in the same cycle never makes room for a push into a full FIFO.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int SOL_W = 23
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [SOL_W-1:0] data_in,
  input  logic             pop,
  output logic [SOL_W-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             overflow_pulse
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SOL_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign empty          = (count == '0);
  assign full           = (count == CNT_W'(DEPTH));
  assign push_ok        = push && !full;
  assign pop_ok         = pop && !empty;
  assign overflow_pulse = push && full;
  assign head           = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; the count alone decides
  // which entries are meaningful, and an unreset array maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: pointer overflow is the modulo-DEPTH wrap.
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers ALU and memory results and broadcasts one per
// cycle, round-robin between sources when both have work pending.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  cdb_arbiter_if.slave  bus
);

  solution_t alu_head;
  solution_t mem_head;
  logic      alu_empty;
  logic      mem_empty;
  logic      alu_full;
  logic      mem_full;
  logic      alu_ovf;
  logic      mem_ovf;
  logic      alu_pop;
  logic      mem_pop;

  logic      grant_valid;
  src_e      grant_src;
  src_e      last_grant;
  src_e      last_grant_nxt;

  logic      cdb_done_q;
  solution_t cdb_solution_q;
  solution_t cdb_solution_nxt;
  src_e      cdb_source_q;
  src_e      cdb_source_nxt;
  logic      overflow_q;

  result_fifo #(.DEPTH(DEPTH), .SOL_W(SOL_W)) u_alu_fifo (
    .clock          (clock),
    .reset          (reset),
    .push           (bus.alu_done),
    .data_in        (bus.alu_solution),
    .pop            (alu_pop),
    .head           (alu_head),
    .empty          (alu_empty),
    .full           (alu_full),
    .overflow_pulse (alu_ovf)
  );

  result_fifo #(.DEPTH(DEPTH), .SOL_W(SOL_W)) u_mem_fifo (
    .clock          (clock),
    .reset          (reset),
    .push           (bus.mem_done),
    .data_in        (bus.mem_solution),
    .pop            (mem_pop),
    .head           (mem_head),
    .empty          (mem_empty),
    .full           (mem_full),
    .overflow_pulse (mem_ovf)
  );

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    grant_valid      = 1'b0;
    grant_src        = SRC_ALU;
    last_grant_nxt   = last_grant;
    cdb_solution_nxt = cdb_solution_q;
    cdb_source_nxt   = cdb_source_q;

    if (!alu_empty && !mem_empty) begin
      grant_valid = 1'b1;
      grant_src   = (last_grant == SRC_ALU) ? SRC_MEM : SRC_ALU;
    end else if (!alu_empty) begin
      grant_valid = 1'b1;
      grant_src   = SRC_ALU;
    end else if (!mem_empty) begin
      grant_valid = 1'b1;
      grant_src   = SRC_MEM;
    end

    alu_pop = grant_valid && (grant_src == SRC_ALU);
    mem_pop = grant_valid && (grant_src == SRC_MEM);

    if (grant_valid) begin
      last_grant_nxt   = grant_src;
      cdb_source_nxt   = grant_src;
      cdb_solution_nxt = (grant_src == SRC_MEM) ? mem_head : alu_head;
    end
  end

  // last_grant resets to memory so the ALU wins the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant     <= SRC_MEM;
      cdb_done_q     <= 1'b0;
      cdb_solution_q <= '0;
      cdb_source_q   <= SRC_ALU;
      overflow_q     <= 1'b0;
    end else begin
      last_grant     <= last_grant_nxt;
      cdb_done_q     <= grant_valid;
      cdb_solution_q <= cdb_solution_nxt;
      cdb_source_q   <= cdb_source_nxt;
      overflow_q     <= overflow_q | alu_ovf | mem_ovf;
    end
  end

  assign bus.alu_full     = alu_full;
  assign bus.mem_full     = mem_full;
  assign bus.cdb_done     = cdb_done_q;
  assign bus.cdb_solution = cdb_solution_q;
  assign bus.cdb_source   = cdb_source_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_cdb_arbiter;
  import tomasulo_pkg::*;

  localparam int DEPTH = 4;
  typedef logic [SOL_W-1:0] sol_t;

  typedef struct {
    logic ad;
    sol_t as;
    logic md;
    sol_t ms;
    logic done;
    logic src;
    sol_t sol;
  } vec_t;

  logic clock;
  logic reset;

  cdb_arbiter_if bus ();

  cdb_arbiter #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per source plus the expected output registers.
  sol_t aq[$];
  sol_t mq[$];
  sol_t acc_a[$];
  sol_t acc_m[$];
  sol_t log_a[$];
  sol_t log_m[$];
  bit   m_last;
  bit   m_done;
  sol_t m_sol;
  bit   m_src;
  bit   m_ovf;

  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    aq.delete();
    mq.delete();
    m_last = 1'b1;
    m_done = 1'b0;
    m_sol  = '0;
    m_src  = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic clear_logs();
    acc_a.delete();
    acc_m.delete();
    log_a.delete();
    log_m.delete();
  endtask

  // One rising edge: decisions use the occupancy seen before the edge.
  task automatic model_edge(input bit ad, input sol_t as, input bit md, input sol_t ms);
    int na;
    int nm;
    bit g;
    bit gsrc;
    na = aq.size();
    nm = mq.size();
    g = 1'b0;
    gsrc = 1'b0;
    if (na > 0 && nm > 0) begin
      g = 1'b1;
      gsrc = !m_last;
    end else if (na > 0) begin
      g = 1'b1;
      gsrc = 1'b0;
    end else if (nm > 0) begin
      g = 1'b1;
      gsrc = 1'b1;
    end
    m_done = g;
    if (g) begin
      m_sol  = gsrc ? mq.pop_front() : aq.pop_front();
      m_src  = gsrc;
      m_last = gsrc;
    end
    if (ad) begin
      if (na < DEPTH) begin
        aq.push_back(as);
        acc_a.push_back(as);
      end else m_ovf = 1'b1;
    end
    if (md) begin
      if (nm < DEPTH) begin
        mq.push_back(ms);
        acc_m.push_back(ms);
      end else m_ovf = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " cdb_done"}, bus.cdb_done, m_done);
    check({tag, " cdb_solution"}, bus.cdb_solution, m_sol);
    check({tag, " cdb_source"}, bus.cdb_source, m_src);
    check({tag, " overflow"}, bus.overflow, m_ovf);
    check({tag, " alu_full"}, bus.alu_full, aq.size() == DEPTH);
    check({tag, " mem_full"}, bus.mem_full, mq.size() == DEPTH);
  endtask

  task automatic cycle(input bit ad, input sol_t as, input bit md, input sol_t ms, input string tag);
    bus.alu_done     = ad;
    bus.alu_solution = as;
    bus.mem_done     = md;
    bus.mem_solution = ms;
    @(posedge clock);
    model_edge(ad, as, md, ms);
    #1;
    compare_all(tag);
    if (bus.cdb_done === 1'b1) begin
      if (bus.cdb_source == SRC_MEM) log_m.push_back(bus.cdb_solution);
      else log_a.push_back(bus.cdb_solution);
    end
    bus.alu_done = 1'b0;
    bus.mem_done = 1'b0;
  endtask

  task automatic do_reset();
    bus.alu_done = 1'b0;
    bus.mem_done = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("reset_hold");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    bit   saw_af;
    bit   saw_mf;
    sol_t a1;
    sol_t m1;
    sol_t a2;
    sol_t m2;
    sol_t s0;
    sol_t x;
    sol_t wv[9];

    reset            = 1'b0;
    bus.alu_done     = 1'b0;
    bus.alu_solution = '0;
    bus.mem_done     = 1'b0;
    bus.mem_solution = '0;

    do_reset();
    compare_all("post_reset");

    // Directed table: simultaneous pairs, then the single-push latency case.
    a1 = 23'h0A1001;
    m1 = 23'h1B2002;
    a2 = 23'h0A3003;
    m2 = 23'h1B4004;
    s0 = 23'h01A5F3;
    vt[0] = '{1'b1, a1,    1'b1, m1,    1'b0, 1'b0, 23'h0};
    vt[1] = '{1'b1, a2,    1'b1, m2,    1'b1, 1'b0, a1};
    vt[2] = '{1'b0, 23'h0, 1'b0, 23'h0, 1'b1, 1'b1, m1};
    vt[3] = '{1'b0, 23'h0, 1'b0, 23'h0, 1'b1, 1'b0, a2};
    vt[4] = '{1'b0, 23'h0, 1'b0, 23'h0, 1'b1, 1'b1, m2};
    vt[5] = '{1'b0, 23'h0, 1'b0, 23'h0, 1'b0, 1'b1, m2};
    vt[6] = '{1'b1, s0,    1'b0, 23'h0, 1'b0, 1'b1, m2};
    vt[7] = '{1'b0, 23'h0, 1'b0, 23'h0, 1'b1, 1'b0, s0};
    vt[8] = '{1'b0, 23'h0, 1'b0, 23'h0, 1'b0, 1'b0, s0};
    for (int i = 0; i < 9; i++) begin
      bus.alu_done     = vt[i].ad;
      bus.alu_solution = vt[i].as;
      bus.mem_done     = vt[i].md;
      bus.mem_solution = vt[i].ms;
      @(posedge clock);
      model_edge(vt[i].ad, vt[i].as, vt[i].md, vt[i].ms);
      #1;
      check($sformatf("vec%0d cdb_done", i), bus.cdb_done, vt[i].done);
      check($sformatf("vec%0d cdb_source", i), bus.cdb_source, vt[i].src);
      check($sformatf("vec%0d cdb_solution", i), bus.cdb_solution, vt[i].sol);
    end
    bus.alu_done = 1'b0;
    bus.mem_done = 1'b0;

    // Five back-to-back memory results with the arbiter draining each cycle.
    clear_logs();
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, sol_t'(23'h2C0000 + i), "mem5");
    repeat (3) cycle(1'b0, '0, 1'b0, '0, "mem5_drain");
    check("mem5 count", log_m.size(), 5);
    for (int i = 0; i < 5 && i < log_m.size(); i++)
      check($sformatf("mem5 order%0d", i), log_m[i], sol_t'(23'h2C0000 + i));
    check("mem5 overflow", bus.overflow, 1'b0);

    // Both sources pushing every cycle: FIFOs fill and extra pushes drop.
    clear_logs();
    saw_af = 1'b0;
    saw_mf = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, sol_t'(23'h0D0000 + i), 1'b1, sol_t'(23'h3E0000 + i), "sat");
      saw_af |= bus.alu_full;
      saw_mf |= bus.mem_full;
    end
    for (int i = 0; i < 2 * DEPTH + 4; i++) cycle(1'b0, '0, 1'b0, '0, "sat_drain");
    check("sat alu_full seen", saw_af, 1'b1);
    check("sat mem_full seen", saw_mf, 1'b1);
    check("sat overflow", bus.overflow, 1'b1);
    check("sat dropped", (log_a.size() + log_m.size()) < 24, 1'b1);
    check("sat alu count", log_a.size(), acc_a.size());
    check("sat mem count", log_m.size(), acc_m.size());
    for (int i = 0; i < log_a.size() && i < acc_a.size(); i++)
      check($sformatf("sat alu order%0d", i), log_a[i], acc_a[i]);
    for (int i = 0; i < log_m.size() && i < acc_m.size(); i++)
      check($sformatf("sat mem order%0d", i), log_m[i], acc_m[i]);

    // Nine ALU pushes interleaved with pops: both pointers wrap twice.
    clear_logs();
    for (int i = 0; i < 9; i++) begin
      wv[i] = sol_t'($urandom) ;
      cycle(1'b1, wv[i], 1'b0, '0, "wrap");
      cycle(1'b0, '0, 1'b0, '0, "wrap");
    end
    repeat (2) cycle(1'b0, '0, 1'b0, '0, "wrap_drain");
    check("wrap count", log_a.size(), 9);
    for (int i = 0; i < 9 && i < log_a.size(); i++)
      check($sformatf("wrap order%0d", i), log_a[i], wv[i]);

    // Randomized traffic in phases of increasing and decreasing load.
    for (int i = 0; i < 400; i++) begin
      int p;
      p = (i < 100) ? 30 : (i < 200) ? 70 : (i < 300) ? 95 : 50;
      cycle(($urandom % 100) < p, sol_t'($urandom), ($urandom % 100) < p, sol_t'($urandom), "rand");
    end
    for (int i = 0; i < 2 * DEPTH + 4; i++) cycle(1'b0, '0, 1'b0, '0, "rand_drain");

    // Reset in the middle of traffic with three entries in each FIFO.
    for (int i = 0; i < 10; i++) begin
      if (aq.size() == 3 && mq.size() == 3) break;
      cycle(1'b1, sol_t'($urandom), 1'b1, sol_t'($urandom), "midrst_fill");
    end
    check("midrst setup reached", (aq.size() == 3) && (mq.size() == 3), 1'b1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("midrst_immediate");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) cycle(1'b0, '0, 1'b0, '0, "midrst_idle");
    x = 23'h5A5A5A;
    cycle(1'b1, x, 1'b0, '0, "midrst_push");
    check("midrst first edge done", bus.cdb_done, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, "midrst_bcast");
    check("midrst second edge done", bus.cdb_done, 1'b1);
    check("midrst second edge sol", bus.cdb_solution, x);
    cycle(1'b0, '0, 1'b0, '0, "midrst_after");
    check("midrst single pulse", bus.cdb_done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
